packet_receiver: RTL

//  Frames the incoming host byte stream (from UART RX) into command packets for the executor.

---
 rtl/packet_receiver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/packet_receiver.sv
// Frames a host byte stream (SYNC, LEN, payload, CSUM) into packets and commits good ones to a 16-byte output bank.
// Optional inter-byte timeout is enabled by defining RX_TIMEOUT_EN.
module packet_receiver #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    output logic       rx_packet_done,
    output logic       rx_packet_error,
    output logic       rx_buffer_valid,
    output logic [7:0] rx_payload_len,
    output logic [7:0] rx_buf0,
    output logic [7:0] rx_buf1,
    output logic [7:0] rx_buf2,
    output logic [7:0] rx_buf3,
    output logic [7:0] rx_buf4,
    output logic [7:0] rx_buf5,
    output logic [7:0] rx_buf6,
    output logic [7:0] rx_buf7,
    output logic [7:0] rx_buf8,
    output logic [7:0] rx_buf9,
    output logic [7:0] rx_buf10,
    output logic [7:0] rx_buf11,
    output logic [7:0] rx_buf12,
    output logic [7:0] rx_buf13,
    output logic [7:0] rx_buf14,
    output logic [7:0] rx_buf15
);

    generate
        if (MAX_LEN > 16 || MAX_LEN < 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
            $error("packet_receiver: MAX_LEN must be 0..16 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t      state, next_state;
    logic [7:0]  len_q;
    logic [7:0]  csum;
    logic [3:0]  idx;
    logic [7:0]  shadow [16];
    logic [7:0]  bank   [16];
    logic        commit;
    logic        fail;
    logic        timeout;

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmr;

    always_ff @(posedge clk) begin
        if (rst || rx_byte_valid || state == S_IDLE) tmr <= '0;
        else                                         tmr <= tmr + 1'b1;
    end

    // A valid byte in the expiry cycle takes priority over the timeout.
    assign timeout = !rx_byte_valid && state != S_IDLE && tmr == T_LAST;
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        fail       = 1'b0;
        if (timeout) begin
            fail       = 1'b1;
            next_state = S_IDLE;
        end else if (rx_byte_valid) begin
            case (state)
                S_IDLE: if (rx_byte == SYNC_BYTE) next_state = S_LEN;
                S_LEN: begin
                    if (rx_byte > 8'(MAX_LEN)) begin
                        fail       = 1'b1;
                        next_state = S_IDLE;
                    end else if (rx_byte == 8'd0) begin
                        next_state = S_CSUM;
                    end else begin
                        next_state = S_DATA;
                    end
                end
                S_DATA: if (8'(idx) + 8'd1 == len_q) next_state = S_CSUM;
                S_CSUM: begin
                    commit     = (rx_byte == csum);
                    fail       = (rx_byte != csum);
                    next_state = S_IDLE;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: the shadow and output banks are reset too, because outputs must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q           <= '0;
            csum            <= '0;
            idx             <= '0;
            rx_packet_done  <= 1'b0;
            rx_packet_error <= 1'b0;
            rx_buffer_valid <= 1'b0;
            rx_payload_len  <= '0;
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= '0;
                bank[i]   <= '0;
            end
        end else begin
            rx_packet_done  <= commit;
            rx_packet_error <= fail;
            if (rx_byte_valid && !timeout) begin
                if (state == S_LEN) begin
                    len_q <= rx_byte;
                    csum  <= rx_byte;
                    idx   <= '0;
                end else if (state == S_DATA) begin
                    shadow[idx] <= rx_byte;
                    csum        <= csum ^ rx_byte;
                    idx         <= idx + 4'd1;
                end
            end
            if (commit) begin
                rx_buffer_valid <= 1'b1;
                rx_payload_len  <= len_q;
                for (int i = 0; i < 16; i++)
                    bank[i] <= (i < int'(len_q)) ? shadow[i] : 8'h00;
            end
        end
    end

    assign rx_buf0  = bank[0];
    assign rx_buf1  = bank[1];
    assign rx_buf2  = bank[2];
    assign rx_buf3  = bank[3];
    assign rx_buf4  = bank[4];
    assign rx_buf5  = bank[5];
    assign rx_buf6  = bank[6];
    assign rx_buf7  = bank[7];
    assign rx_buf8  = bank[8];
    assign rx_buf9  = bank[9];
    assign rx_buf10 = bank[10];
    assign rx_buf11 = bank[11];
    assign rx_buf12 = bank[12];
    assign rx_buf13 = bank[13];
    assign rx_buf14 = bank[14];
    assign rx_buf15 = bank[15];

endmodule
